muldiv_sequencer: RTL

Multi-cycle multiply/divide sequencer for the execute stage of the pipelined core. It accepts MULT/MULTU/DIV/DIVU from EX, runs a 32-iteration shift-add or restoring-divide loop, and owns the architectural HI/LO registers. It also generates the pipeline stall needed while the unit is busy. EX operands arrive already selected by the operand muxes (rs value and forwarded rt value).

---
 rtl/muldiv_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// Runs a 32-step shift-add multiply or restoring divide on operand
// magnitudes, applies sign correction in a final FIX cycle, and owns HI/LO.
// Raises a combinational stall while busy if EX needs the unit or HI/LO.
module muldiv_sequencer (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic        readHiLo,
    input  logic        writeHi,
    input  logic        writeLo,
    input  logic [31:0] writeData,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        stall,
    output logic [31:0] hiOut,
    output logic [31:0] loOut
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [31:0] mcand;    // mul: |multiplicand|; div: |divisor|
    logic        is_div;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    // Operand magnitudes; op[0] marks the signed forms (MULT, DIV).
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    assign a_mag = (op[0] && operandA[31]) ? (~operandA + 32'd1) : operandA;
    assign b_mag = (op[0] && operandB[31]) ? (~operandB + 32'd1) : operandB;

    // One multiply step: conditional add into the upper half; the carry
    // becomes the new MSB after the right shift.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);

    // One restoring-divide step: shift {rem,quot} left and trial-subtract.
    // The shifted remainder needs 33 bits; a borrow shows up in bit 32.
    logic [32:0] rem_sh;
    logic [32:0] div_diff;
    assign rem_sh   = {acc[63:32], acc[31]};
    assign div_diff = rem_sh - {1'b0, mcand};

    // Sign correction applied in FIX.
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    assign prod_fix = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    assign quot_fix = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    assign rem_fix  = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];

    // Sequencer state, iteration datapath and HI/LO ownership.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            count    <= 5'd0;
            acc      <= 64'd0;
            mcand    <= 32'd0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // MTHI/MTLO land here; a same-cycle start's result
                    // overwrites them at FIX.
                    if (writeHi) hi_q <= writeData;
                    if (writeLo) lo_q <= writeData;
                    if (start && !flush) begin
                        is_div   <= op[1];
                        sign_a   <= op[0] & operandA[31];
                        sign_b   <= op[0] & operandB[31];
                        div_zero <= (operandB == 32'd0);
                        if (op[1]) begin
                            acc   <= {32'd0, a_mag};
                            mcand <= b_mag;
                        end else begin
                            acc   <= {32'd0, b_mag};
                            mcand <= a_mag;
                        end
                        count <= 5'd0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        if (is_div) begin
                            if (!div_diff[32])
                                acc <= {div_diff[31:0], acc[30:0], 1'b1};
                            else
                                acc <= {rem_sh[31:0], acc[30:0], 1'b0};
                        end else begin
                            acc <= {mul_sum, acc[31:1]};
                        end
                        count <= count + 5'd1;
                        if (count == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            // Divide by zero: remainder path already yields
                            // the dividend; only the quotient is forced.
                            lo_q <= div_zero ? 32'hFFFF_FFFF : quot_fix;
                            hi_q <= rem_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                        done_q <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign stall = busy & (start | readHiLo | writeHi | writeLo);
    assign done  = done_q;
    assign hiOut = hi_q;
    assign loOut = lo_q;

endmodule
